// File: rtl/fswm_pkg.sv
// Shared definitions for the FSWM waveform-memory load path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fswm_pkg;

  localparam int FSWM_AW = 12;  // waveform memory address width (depth 4096)
  localparam int FSWM_DW = 12;  // sample width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } fswm_ld_state_t;

endpackage

// File: rtl/fswm_skid2.sv
// Two-entry skid buffer with registered ready, feeding the load sequencer.
// Latency: an entry pushed at edge N is visible at head from edge N (head_vld next cycle).
// Backpressure: push_rdy is registered; it is high only when 'allow' and a free slot remains.
// Ports:
//   Clock, Reset         shared clock / async active-high reset
//   allow                caller permits accepting in the coming cycle
//   flush                drop all entries and any push on this edge
//   push_vld/_dat/_rdy   upstream valid/ready handshake
//   pop                  consume head entry (ignored when empty)
//   head_vld, head_dat   oldest entry
module fswm_skid2 #(
  parameter int DW = 12
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          allow,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic          head_vld,
  output logic [DW-1:0] head_dat
);

  logic [DW-1:0] mem [2];
  logic          wp;
  logic          rp;
  logic [1:0]    cnt;
  logic [1:0]    cnt_nx;
  logic          push;
  logic          do_pop;

  assign push     = push_vld && push_rdy;
  assign do_pop   = pop && (cnt != 2'd0);
  assign cnt_nx   = flush ? 2'd0 : (cnt + {1'b0, push} - {1'b0, do_pop});
  assign head_vld = (cnt != 2'd0);
  assign head_dat = mem[rp];

  // Ready is computed from the post-edge occupancy so it never advertises
  // a slot that will not exist when the next transfer lands.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt      <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      push_rdy <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      push_rdy <= allow && (cnt_nx != 2'd2);
      if (flush) begin
        wp <= 1'b0;
        rp <= 1'b0;
      end else begin
        if (push)   wp <= ~wp;
        if (do_pop) rp <= ~rp;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (push && !flush) mem[wp] <= push_dat;
  end

endmodule

// File: rtl/fswm_load_seq.sv
// Write sequencer: turns a valid/ready sample burst into registered FSWM writes from a base address.
// Latency: sample accepted at edge N is written (Wout) at edge N+1 at the earliest; 1 write/cycle.
// Backpressure: InReady registered, high only in LOAD with buffer space and samples still owed.
// Ports:
//   Clock, Reset               clock / async active-high reset
//   Start, Abort               burst start pulse (IDLE only) / abort level (LOAD only)
//   BaseAddr, Length           first address and sample count (1..2**AW), captured on Start
//   InValid, InData, InReady   sample handshake
//   Wout, Aout, Dout           registered write strobe, address, data
//   Busy, Done, Err            burst active / normal-finish pulse / error-or-abort pulse
module fswm_load_seq
  import fswm_pkg::*;
#(
  parameter int AW = FSWM_AW,
  parameter int DW = FSWM_DW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Abort,
  input  logic [AW-1:0] BaseAddr,
  input  logic [AW:0]   Length,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  output logic          InReady,
  output logic          Wout,
  output logic [AW-1:0] Aout,
  output logic [DW-1:0] Dout,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  fswm_ld_state_t state;
  fswm_ld_state_t state_nx;
  logic [AW-1:0]  addr;
  logic [AW:0]    rem;      // writes still to issue
  logic [AW:0]    acc_rem;  // samples still to accept
  logic [AW:0]    acc_nx;
  logic           head_vld;
  logic [DW-1:0]  head_dat;
  logic           push;
  logic           start_ok;
  logic           start_bad;
  logic           wr_go;
  logic           last_wr;
  logic           abort_go;
  logic           allow;

  assign push      = InValid && InReady;
  assign start_ok  = (state == IDLE) && Start && (Length != '0);
  assign start_bad = (state == IDLE) && Start && (Length == '0);
  assign wr_go     = (state == LOAD) && head_vld && (rem != '0);
  assign last_wr   = wr_go && (rem == (AW+1)'(1));
  // A final write on the abort edge finishes the burst normally instead.
  assign abort_go  = (state == LOAD) && Abort && !last_wr;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = LOAD;
      LOAD: begin
        if (last_wr)       state_nx = FIN;
        else if (abort_go) state_nx = IDLE;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    if (start_ok)      acc_nx = Length;
    else if (abort_go) acc_nx = '0;
    else               acc_nx = acc_rem - {{AW{1'b0}}, push};
  end

  // Accept only while a further sample is owed, so nothing beyond Length
  // is ever taken from the source.
  assign allow = (state_nx == LOAD) && (acc_nx != '0);

  fswm_skid2 #(.DW(DW)) u_skid (
    .Clock    (Clock),
    .Reset    (Reset),
    .allow    (allow),
    .flush    (abort_go),
    .push_vld (InValid),
    .push_dat (InData),
    .push_rdy (InReady),
    .pop      (wr_go),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      addr    <= '0;
      rem     <= '0;
      acc_rem <= '0;
      Wout    <= 1'b0;
      Aout    <= '0;
      Dout    <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state   <= state_nx;
      acc_rem <= acc_nx;
      Wout    <= 1'b0;
      Done    <= 1'b0;
      Err     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            addr <= BaseAddr;
            rem  <= Length;
            Busy <= 1'b1;
          end else if (start_bad) begin
            Err <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_go) begin
            Wout <= 1'b1;
            Aout <= addr;
            Dout <= head_dat;
            addr <= addr + AW'(1);  // wraps at memory depth
            rem  <= rem - (AW+1)'(1);
          end
          if (abort_go) begin
            Busy <= 1'b0;
            Err  <= 1'b1;
          end
        end
        FIN: begin
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fswm_load_seq.sv
module tb_fswm_load_seq;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        Abort;
  logic [11:0] BaseAddr;
  logic [12:0] Length;
  logic        InValid;
  logic [11:0] InData;
  logic        InReady;
  logic        Wout;
  logic [11:0] Aout;
  logic [11:0] Dout;
  logic        Busy;
  logic        Done;
  logic        Err;

  fswm_load_seq dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Abort    (Abort),
    .BaseAddr (BaseAddr),
    .Length   (Length),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .Wout     (Wout),
    .Aout     (Aout),
    .Dout     (Dout),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct packed {
    int          cyc;
    logic [11:0] a;
    logic [11:0] d;
  } wr_t;

  wr_t         wr_q[$];
  int          acc_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [11:0] src_q[$];
  logic        src_on;
  logic        hold;
  logic [63:0] pat;
  int          pi;
  int          cyc_n;
  int          n_chk;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: at the falling edge record registered outputs, then drive the source.
  task automatic tick();
    logic v;
    @(negedge Clock);
    cyc_n++;
    if (Wout) wr_q.push_back('{cyc_n, Aout, Dout});
    if (Done) done_q.push_back(cyc_n);
    if (Err)  err_q.push_back(cyc_n);
    v = src_on && (src_q.size() != 0) && (hold || ((pi < 64) ? pat[pi] : pat[63]));
    if (src_on) pi++;
    InValid = v;
    InData  = v ? src_q[0] : 12'h000;
    hold    = v && !InReady;
    if (v && InReady) begin
      acc_q.push_back(cyc_n + 1);
      void'(src_q.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    wr_q.delete(); acc_q.delete(); done_q.delete(); err_q.delete(); src_q.delete();
    src_on = 1'b0; hold = 1'b0; pi = 0; InValid = 1'b0; InData = 12'h000;
  endtask

  // Start is sampled at edge s; the source pattern starts at edge s+1.
  task automatic start_burst(input logic [11:0] base, input logic [12:0] len,
                             input logic [63:0] p, input logic ab, output int s);
    tick();
    src_on = 1'b1; pat = p; pi = 0;
    Start = 1'b1; Abort = ab; BaseAddr = base; Length = len;
    s = cyc_n + 1;
    tick();
    Start = 1'b0; Abort = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int i, input int cyc,
                          input logic [11:0] a, input logic [11:0] d);
    if (i < wr_q.size()) begin
      check({tag, "_cyc"}, 32'(wr_q[i].cyc), 32'(cyc));
      check({tag, "_addr"}, 32'(wr_q[i].a), 32'(a));
      check({tag, "_data"}, 32'(wr_q[i].d), 32'(d));
    end else begin
      check({tag, "_missing"}, 32'(wr_q.size()), 32'(i + 1));
    end
  endtask

  task automatic check_one(input string tag, input int q_size, input int q_first, input int exp_cyc);
    check({tag, "_n"}, 32'(q_size), 32'd1);
    if (q_size > 0) check({tag, "_cyc"}, 32'(q_first), 32'(exp_cyc));
  endtask

  initial begin
    int s;
    int bad_a, bad_d, bad_c, dup;
    logic seen [4096];
    logic [11:0] exp_a [4];

    n_chk = 0; n_err = 0; cyc_n = 0; pat = '1;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; BaseAddr = '0; Length = '0;
    clr();
    run(3);
    check("rst_inready", 32'(InReady), 32'd0);
    check("rst_wout",    32'(Wout),    32'd0);
    check("rst_aout",    32'(Aout),    32'd0);
    check("rst_dout",    32'(Dout),    32'd0);
    check("rst_busy",    32'(Busy),    32'd0);
    check("rst_done",    32'(Done),    32'd0);
    check("rst_err",     32'(Err),     32'd0);
    Reset = 1'b0;
    run(2);

    // Base 0, Length 4, continuous data
    clr();
    for (int i = 0; i < 4; i++) src_q.push_back(12'(12'h111 * (i + 1)));
    start_burst(12'h000, 13'd4, '1, 1'b0, s);
    check("t1_busy", 32'(Busy), 32'd1);
    run(10);
    check("t1_nwr", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_wr("t1", i, s + 2 + i, 12'(i), 12'(12'h111 * (i + 1)));
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size() && i < wr_q.size())
        check("t1_latency", 32'(wr_q[i].cyc - acc_q[i]), 32'd1);
    check_one("t1_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 6);
    check("t1_nerr", 32'(err_q.size()), 32'd0);
    check("t1_busy_end", 32'(Busy), 32'd0);

    // Address wrap at the top of memory
    clr();
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 4; i++) src_q.push_back(12'(12'hA01 + i));
    start_burst(12'hFFE, 13'd4, '1, 1'b0, s);
    run(10);
    check("t2_nwr", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_wr("t2", i, s + 2 + i, exp_a[i], 12'(12'hA01 + i));

    // Gapped source: valid 1,0,1,0,1
    clr();
    for (int i = 0; i < 3; i++) src_q.push_back(12'(12'hD01 + i));
    start_burst(12'h040, 13'd3, 64'h15, 1'b0, s);
    run(12);
    check("t3_nacc", 32'(acc_q.size()), 32'd3);
    check("t3_nwr", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc_q.size()) check("t3_acc_cyc", 32'(acc_q[i]), 32'(s + 1 + 2 * i));
      check_wr("t3", i, s + 2 + 2 * i, 12'(12'h040 + i), 12'(12'hD01 + i));
    end
    check_one("t3_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 7);

    // Source holds more samples than Length
    clr();
    for (int i = 0; i < 6; i++) src_q.push_back(12'(12'hE01 + i));
    start_burst(12'h010, 13'd2, '1, 1'b0, s);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cyc_n == s + 1) check("t4_rdy_mid", 32'(InReady), 32'd1);
      if (cyc_n == s + 2) check("t4_rdy_drop", 32'(InReady), 32'd0);
    end
    check("t4_nacc", 32'(acc_q.size()), 32'd2);
    check("t4_left", 32'(src_q.size()), 32'd4);
    check("t4_rdy_end", 32'(InReady), 32'd0);
    check("t4_nwr", 32'(wr_q.size()), 32'd2);
    check_wr("t4", 1, s + 3, 12'h011, 12'hE02);
    check_one("t4_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 4);

    // Abort sampled on the edge of the third write, then restart
    clr();
    for (int i = 0; i < 8; i++) src_q.push_back(12'(12'hB01 + i));
    start_burst(12'h100, 13'd8, '1, 1'b0, s);
    while (cyc_n < s + 3) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_rdy", 32'(InReady), 32'd0);
    run(8);
    check("t5_nwr", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_wr("t5", i, s + 2 + i, 12'(12'h100 + i), 12'(12'hB01 + i));
    check_one("t5_err", err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, s + 4);
    check("t5_ndone", 32'(done_q.size()), 32'd0);
    clr();
    src_q.push_back(12'hC01); src_q.push_back(12'hC02);
    start_burst(12'h200, 13'd2, '1, 1'b0, s);
    run(8);
    check("t5r_nwr", 32'(wr_q.size()), 32'd2);
    check_wr("t5r", 0, s + 2, 12'h200, 12'hC01);
    check_wr("t5r", 1, s + 3, 12'h201, 12'hC02);
    check_one("t5r_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 4);
    check("t5r_nerr", 32'(err_q.size()), 32'd0);

    // Start and Abort together in IDLE: Start wins
    clr();
    src_q.push_back(12'h999);
    start_burst(12'h7FF, 13'd1, '1, 1'b1, s);
    run(6);
    check("t6_nwr", 32'(wr_q.size()), 32'd1);
    check_wr("t6", 0, s + 2, 12'h7FF, 12'h999);
    check_one("t6_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 3);
    check("t6_nerr", 32'(err_q.size()), 32'd0);

    // Abort on the edge of the last write: Done, no Err
    clr();
    src_q.push_back(12'h701); src_q.push_back(12'h702);
    start_burst(12'h050, 13'd2, '1, 1'b0, s);
    while (cyc_n < s + 2) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    run(6);
    check("t7_nwr", 32'(wr_q.size()), 32'd2);
    check_one("t7_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 4);
    check("t7_nerr", 32'(err_q.size()), 32'd0);

    // Length 0
    clr();
    start_burst(12'h123, 13'd0, '1, 1'b0, s);
    check("t8_busy", 32'(Busy), 32'd0);
    run(4);
    check_one("t8_err", err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, s);
    check("t8_nwr", 32'(wr_q.size()), 32'd0);
    check("t8_ndone", 32'(done_q.size()), 32'd0);

    // Full-depth burst from a non-zero base
    clr();
    for (int i = 0; i < 4096; i++) src_q.push_back(12'(i) ^ 12'h5A5);
    start_burst(12'h800, 13'h1000, '1, 1'b0, s);
    run(4096 + 8);
    bad_a = 0; bad_d = 0; bad_c = 0; dup = 0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i].a != 12'(12'h800 + i)) bad_a++;
      if (wr_q[i].d != (12'(i) ^ 12'h5A5)) bad_d++;
      if (wr_q[i].cyc != s + 2 + i) bad_c++;
      if (seen[wr_q[i].a]) dup++;
      seen[wr_q[i].a] = 1'b1;
    end
    check("t9_nwr", 32'(wr_q.size()), 32'd4096);
    check("t9_bad_addr", 32'(bad_a), 32'd0);
    check("t9_bad_data", 32'(bad_d), 32'd0);
    check("t9_bad_cyc", 32'(bad_c), 32'd0);
    check("t9_dup_addr", 32'(dup), 32'd0);
    check_one("t9_done", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 4098);
    check("t9_nerr", 32'(err_q.size()), 32'd0);

    // Reset in the middle of a burst
    clr();
    for (int i = 0; i < 8; i++) src_q.push_back(12'(12'hF01 + i));
    start_burst(12'h300, 13'd8, '1, 1'b0, s);
    while (cyc_n < s + 3) tick();
    check("t10_wout_pre", 32'(Wout), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("t10_wout",    32'(Wout),    32'd0);
    check("t10_aout",    32'(Aout),    32'd0);
    check("t10_dout",    32'(Dout),    32'd0);
    check("t10_busy",    32'(Busy),    32'd0);
    check("t10_inready", 32'(InReady), 32'd0);
    src_on = 1'b0; src_q.delete(); InValid = 1'b0;
    run(3);
    Reset = 1'b0;
    run(6);
    check("t10_nwr", 32'(wr_q.size()), 32'd2);
    check("t10_ndone", 32'(done_q.size()), 32'd0);
    check("t10_nerr", 32'(err_q.size()), 32'd0);
    check("t10_busy_end", 32'(Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
